// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the iterative multiply/divide unit
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } mdu_state_e;

  localparam int MDU_MAX_WIDTH = 64;
  localparam logic [MDU_MAX_WIDTH-1:0] DIVZERO_LO = '1;

  function automatic logic op_is_signed(mdu_op_e o);
    return (o == MDU_MULT) || (o == MDU_DIV);
  endfunction

  function automatic logic op_is_div(mdu_op_e o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_addsub.sv
// rtl/mdu_addsub.sv - N-bit add/subtract with carry out, shared by multiply and divide steps
module mdu_addsub #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] full;

  // Subtraction is a + ~b + 1, so cout=1 means no borrow (a >= b).
  assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{N{1'b0}}, sub};
  assign sum  = full[N-1:0];
  assign cout = full[N];

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit holding HI/LO
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e         state, state_nxt;
  mdu_op_e            op_e;
  logic               div_q, neg_q, neg_r, divzero_q;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   acc_hi, acc_lo;
  logic [WIDTH:0]     as_a, as_b, as_sum;
  logic               as_sub, as_cout;
  logic [2*WIDTH-1:0] step_acc, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_e  = mdu_op_e'(op);
  assign sa    = op_is_signed(op_e) & src_a[WIDTH-1];
  assign sb    = op_is_signed(op_e) & src_b[WIDTH-1];
  assign mag_a = sa ? -src_a : src_a;
  assign mag_b = sb ? -src_b : src_b;

  assign acc_hi = acc[2*WIDTH-1:WIDTH];
  assign acc_lo = acc[WIDTH-1:0];
  assign busy   = (state != S_IDLE);

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    as_sub   = 1'b0;
    as_a     = {1'b0, acc_hi};
    as_b     = acc[0] ? {1'b0, opb} : '0;
    step_acc = {as_sum, acc_lo[WIDTH-1:1]};
    if (div_q) begin
      as_sub   = 1'b1;
      as_a     = {acc_hi, acc_lo[WIDTH-1]};
      as_b     = {1'b0, opb};
      step_acc = as_cout ? {as_sum[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1}
                         : {as_a[WIDTH-1:0],   acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  mdu_addsub #(.N(WIDTH+1)) u_addsub (
    .a    (as_a),
    .b    (as_b),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout)
  );

  // With a zero divisor every trial subtract succeeds, so the remainder
  // path shifts the dividend back out and HI recovers src_a unaided.
  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc_lo : acc_lo;
  assign rem_fix  = neg_r ? -acc_hi : acc_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      div_q       <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      divzero_q   <= 1'b0;
      opb         <= '0;
      acc         <= '0;
      cnt         <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            div_q     <= op_is_div(op_e);
            neg_q     <= sa ^ sb;
            neg_r     <= sa;
            divzero_q <= op_is_div(op_e) && (src_b == '0);
            opb       <= mag_b;
            acc       <= {{WIDTH{1'b0}}, mag_a};
            cnt       <= CW'(WIDTH-1);
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_RUN: begin
          acc <= step_acc;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          if (div_q) begin
            hi <= rem_fix;
            lo <= divzero_q ? DIVZERO_LO[WIDTH-1:0] : quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done        <= 1'b1;
          div_by_zero <= div_q & divzero_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0, src_b = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  // Launches one op and returns at the negedge where busy has dropped.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dz: got %b expected 0", div_by_zero); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    reset = 1'b0;
  endtask

  task automatic test_multu();
    int cyc;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    vectors++; if (cyc !== 33) begin miscompares++; $display("FAIL multu_busy_cycles: got %0d expected 33", cyc); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL multu_done: got %b expected 1", done); end
    vectors++; if (hi !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    vectors++; if (lo !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_mult();
    int cyc;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, cyc);
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hi); end
    vectors++; if (lo !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mult_neg_lo: got %h expected ffffffeb", lo); end
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, cyc);
    vectors++; if (hi !== 32'h4000_0000) begin miscompares++; $display("FAIL mult_min_hi: got %h expected 40000000", hi); end
    vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL mult_min_lo: got %h expected 00000000", lo); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL mult_dz: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_div();
    int cyc;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, cyc);
    vectors++; if (lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
    run_op(OP_DIVU, 32'd100, 32'd7, cyc);
    vectors++; if (lo !== 32'd14) begin miscompares++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
    vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    vectors++; if (lo !== 32'h8000_0000) begin miscompares++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end
    vectors++; if (cyc !== 33) begin miscompares++; $display("FAIL div_busy_cycles: got %0d expected 33", cyc); end
  endtask

  task automatic test_div_by_zero();
    int cyc;
    run_op(OP_DIVU, 32'd5, 32'd0, cyc);
    vectors++; if (cyc !== 33) begin miscompares++; $display("FAIL dz_busy_cycles: got %0d expected 33", cyc); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL dz_done: got %b expected 1", done); end
    vectors++; if (div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
    vectors++; if (hi !== 32'd5) begin miscompares++; $display("FAIL dz_hi: got %h expected 00000005", hi); end
    vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL dz_lo: got %h expected ffffffff", lo); end
    @(negedge clk);
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL dz_flag_pulse: got %b expected 0", div_by_zero); end
    run_op(OP_DIVU, 32'd6, 32'd3, cyc);
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL dz_clear_flag: got %b expected 0", div_by_zero); end
    vectors++; if (lo !== 32'd2) begin miscompares++; $display("FAIL dz_clear_lo: got %h expected 00000002", lo); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL dz_clear_hi: got %h expected 00000000", hi); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy === 1'b1) cyc++;
      @(negedge clk);
    end
    start = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd9;
    if (busy === 1'b1) cyc++;
    @(negedge clk);
    start = 1'b0; src_a = 32'd100;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    vectors++; if (cyc !== 33) begin miscompares++; $display("FAIL ignore_busy_cycles: got %0d expected 33", cyc); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL ignore_hi: got %h expected 00000000", hi); end
    vectors++; if (lo !== 32'd12) begin miscompares++; $display("FAIL ignore_lo: got %h expected 0000000c", lo); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done: got %b expected 1", done); end
    start = 1'b1; op = OP_MULTU; src_a = 32'd5; src_b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accepted: got %b expected 1", busy); end
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    vectors++; if (cyc !== 33) begin miscompares++; $display("FAIL b2b_busy_cycles: got %0d expected 33", cyc); end
    vectors++; if (lo !== 32'd30) begin miscompares++; $display("FAIL b2b_lo: got %h expected 0000001e", lo); end
  endtask

  task automatic test_mt_and_async_reset();
    int cyc;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    vectors++; if (hi !== 32'h1234) begin miscompares++; $display("FAIL mthi: got %h expected 00001234", hi); end
    vectors++; if (lo !== 32'h5678) begin miscompares++; $display("FAIL mtlo: got %h expected 00005678", lo); end
    start = 1'b1; op = OP_DIVU; src_a = 32'd9; src_b = 32'd2;
    hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    repeat (8) @(negedge clk);
    vectors++; if (hi !== 32'h1234) begin miscompares++; $display("FAIL hold_hi_start_priority: got %h expected 00001234", hi); end
    vectors++; if (lo !== 32'h5678) begin miscompares++; $display("FAIL hold_lo_run: got %h expected 00005678", lo); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL run_busy: got %b expected 1", busy); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL async_reset_hi: got %h expected 00000000", hi); end
    vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL async_reset_lo: got %h expected 00000000", lo); end
    @(negedge clk);
    reset = 1'b0;
    run_op(OP_MULT, 32'd2, 32'd2, cyc);
    vectors++; if (cyc !== 33) begin miscompares++; $display("FAIL post_reset_cycles: got %0d expected 33", cyc); end
    vectors++; if (lo !== 32'd4) begin miscompares++; $display("FAIL post_reset_lo: got %h expected 00000004", lo); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL post_reset_hi: got %h expected 00000000", hi); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_by_zero();
    test_back_to_back();
    test_mt_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
